// File: rtl/alu_pkg.sv
// Shared types and constants for the EBOX ALU array.
package alu_pkg;

    typedef struct packed {
        logic [3:0] s;
        logic       boole;
        logic       cin;
        logic       dbl;
    } AluOp;

    typedef enum logic {
        IDLE = 1'b0,
        DHI  = 1'b1
    } AluState;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b1001;

endpackage

// File: rtl/alu_lookahead.sv
// 10179-style carry lookahead across four generate/propagate pairs.
module alu_lookahead (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic [3:1] c_o,
    output logic       gg_o,
    output logic       gp_o
);

    assign c_o[1] = g_i[0] | (p_i[0] & c_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);

    assign gg_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    assign gp_o = &p_i;

endmodule

// File: rtl/mc10181.sv
// 4-bit mc10181 function slice: arithmetic F = X plus Y plus Cn, logic F = ~(X ^ Y).
module mc10181 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       c_i,
    output logic [3:0] f_o,
    output logic       g_o,
    output logic       p_o
);

    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] h;
    logic [3:1] c_int;

    // y is always a subset of x, so x serves directly as the propagate term
    assign x = a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}});
    assign y = (a_i & ~b_i & {4{s_i[2]}}) | (a_i & b_i & {4{s_i[3]}});
    assign h = x & ~y;

    alu_lookahead u_bit_cla (
        .g_i  (y),
        .p_i  (x),
        .c_i  (c_i),
        .c_o  (c_int),
        .gg_o (g_o),
        .gp_o (p_o)
    );

    assign f_o = m_i ? ~h : (h ^ {c_int, c_i});

endmodule

// File: rtl/ebox_alu_array.sv
// Multi-slice EBOX ALU: single-word ops in one cycle, double-word ops in two via a carry register.
module ebox_alu_array
    import alu_pkg::*;
#(
    parameter  int SLICES    = 9,
    parameter  bit DOUBLE_EN = 1'b1,
    localparam int W         = 4 * SLICES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:3]   op_s,
    input  logic         op_boole,
    input  logic         op_cin,
    input  logic         op_dbl,
    input  logic [0:W-1] a_hi,
    input  logic [0:W-1] b_hi,
    input  logic [0:W-1] a_lo,
    input  logic [0:W-1] b_lo,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] f_hi,
    output logic [0:W-1] f_lo,
    output logic         cout,
    output logic         zero
);

    localparam int NGRP = (SLICES + 3) / 4;

    AluOp            op_in;
    AluState         state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    f_hi_q, f_hi_d, f_lo_q, f_lo_d;
    logic [W-1:0]    a_hi_q, a_hi_d, b_hi_q, b_hi_d;
    logic [3:0]      s_q, s_d;
    logic            boole_q, boole_d;
    logic            cout_q, cout_d, zero_q, zero_d, cy_q, cy_d;

    logic [W-1:0]    alu_a, alu_b, alu_f;
    logic [3:0]      alu_s;
    logic            alu_m, alu_cin, arith_co, accept;
    logic [NGRP*4-1:0] sg, sp, slice_c;
    logic [NGRP-1:0] gg, gp;
    logic [NGRP:0]   gcin;
    logic [3:1]      la_c [NGRP];
    logic            unused_pad_c;

    assign op_in    = '{s: op_s, boole: op_boole, cin: op_cin, dbl: op_dbl};
    assign in_ready = (state_q == IDLE) & (!out_valid_q | out_ready) & !reset;
    assign accept   = in_valid & in_ready;

    // One slice array serves both phases; the high phase replays latched operands.
    always_comb begin
        if (state_q == DHI) begin
            alu_a = a_hi_q; alu_b = b_hi_q; alu_s = s_q; alu_m = boole_q; alu_cin = cy_q;
        end else begin
            alu_a = a_lo; alu_b = b_lo; alu_s = op_in.s; alu_m = op_in.boole; alu_cin = op_in.cin;
        end
    end

    for (genvar k = 0; k < NGRP * 4; k++) begin : g_slice
        if (k < SLICES) begin : g_real
            mc10181 u_slice (
                .a_i (alu_a[4*k +: 4]),
                .b_i (alu_b[4*k +: 4]),
                .s_i (alu_s),
                .m_i (alu_m),
                .c_i (slice_c[k]),
                .f_o (alu_f[4*k +: 4]),
                .g_o (sg[k]),
                .p_o (sp[k])
            );
        end else begin : g_pad
            // Padding slices pass carries through so the group outputs stay exact.
            assign sg[k] = 1'b0;
            assign sp[k] = 1'b1;
        end
    end

    for (genvar j = 0; j < NGRP; j++) begin : g_group
        alu_lookahead u_grp_cla (
            .g_i  (sg[4*j +: 4]),
            .p_i  (sp[4*j +: 4]),
            .c_i  (gcin[j]),
            .c_o  (la_c[j]),
            .gg_o (gg[j]),
            .gp_o (gp[j])
        );
    end

    always_comb begin
        logic c;
        c = alu_cin;
        for (int j = 0; j < NGRP; j++) begin
            gcin[j] = c;
            c = gg[j] | (gp[j] & c);
        end
        gcin[NGRP] = c;
    end

    always_comb begin
        slice_c = '0;
        for (int k = 0; k < NGRP * 4; k++) begin
            slice_c[k] = ((k % 4) == 0) ? gcin[k / 4] : la_c[k / 4][k % 4];
        end
    end

    assign unused_pad_c = ^slice_c;
    assign arith_co     = !alu_m & gcin[NGRP];

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        f_hi_d      = f_hi_q;
        f_lo_d      = f_lo_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        cy_d        = cy_q;
        a_hi_d      = a_hi_q;
        b_hi_d      = b_hi_q;
        s_d         = s_q;
        boole_d     = boole_q;
        if (state_q == DHI) begin
            f_hi_d      = alu_f;
            cout_d      = arith_co;
            zero_d      = (alu_f == '0) && (f_lo_q == '0);
            out_valid_d = 1'b1;
            state_d     = IDLE;
        end else if (accept) begin
            f_lo_d = alu_f;
            if (op_in.dbl && DOUBLE_EN) begin
                cy_d        = arith_co;
                a_hi_d      = a_hi;
                b_hi_d      = b_hi;
                s_d         = op_in.s;
                boole_d     = op_in.boole;
                out_valid_d = 1'b0;
                state_d     = DHI;
            end else begin
                f_hi_d      = '0;
                cout_d      = arith_co;
                zero_d      = (alu_f == '0);
                out_valid_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            f_hi_q      <= '0;
            f_lo_q      <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            cy_q        <= 1'b0;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            s_q         <= '0;
            boole_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            f_hi_q      <= f_hi_d;
            f_lo_q      <= f_lo_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            cy_q        <= cy_d;
            a_hi_q      <= a_hi_d;
            b_hi_q      <= b_hi_d;
            s_q         <= s_d;
            boole_q     <= boole_d;
        end
    end

    assign out_valid = out_valid_q;
    assign f_hi      = f_hi_q;
    assign f_lo      = f_lo_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_ebox_alu_array.sv
// Directed plus randomized bench for ebox_alu_array against a datasheet-level ALU model.
module tb_ebox_alu_array;
    import alu_pkg::*;

    localparam int W = 36;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         co;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, op_boole, op_cin, op_dbl;
    logic [0:3]   op_s;
    logic [0:W-1] a_hi, b_hi, a_lo, b_lo, f_hi, f_lo;
    logic         out_valid, out_ready, cout, zero;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    bit   in_dhi = 1'b0;

    always #5 clk = ~clk;

    ebox_alu_array #(.SLICES(9), .DOUBLE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_s(op_s), .op_boole(op_boole), .op_cin(op_cin), .op_dbl(op_dbl),
        .a_hi(a_hi), .b_hi(b_hi), .a_lo(a_lo), .b_lo(b_lo),
        .out_valid(out_valid), .out_ready(out_ready),
        .f_hi(f_hi), .f_lo(f_lo), .cout(cout), .zero(zero)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mc10181 function table: logic results, or arithmetic as "first plus second plus Cn".
    function automatic logic [W:0] ref_alu(input logic [3:0] s, input logic m,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        logic [W-1:0] ones, x, y, f;
        ones = '1;
        if (m) begin
            case (s)
                4'd0:  f = ~a;        4'd1:  f = ~(a | b);
                4'd2:  f = ~a & b;    4'd3:  f = '0;
                4'd4:  f = ~(a & b);  4'd5:  f = ~b;
                4'd6:  f = a ^ b;     4'd7:  f = a & ~b;
                4'd8:  f = ~a | b;    4'd9:  f = ~(a ^ b);
                4'd10: f = b;         4'd11: f = a & b;
                4'd12: f = ones;      4'd13: f = a | ~b;
                4'd14: f = a | b;     default: f = a;
            endcase
            return {1'b0, f};
        end
        case (s)
            4'd0:  begin x = a;          y = '0;         end
            4'd1:  begin x = a | b;      y = '0;         end
            4'd2:  begin x = a | ~b;     y = '0;         end
            4'd3:  begin x = ones;       y = '0;         end
            4'd4:  begin x = a;          y = a & ~b;     end
            4'd5:  begin x = a | b;      y = a & ~b;     end
            4'd6:  begin x = a;          y = ~b;         end
            4'd7:  begin x = a & ~b;     y = ones;       end
            4'd8:  begin x = a;          y = a & b;      end
            4'd9:  begin x = a;          y = b;          end
            4'd10: begin x = a | ~b;     y = a & b;      end
            4'd11: begin x = a & b;      y = ones;       end
            4'd12: begin x = a;          y = a;          end
            4'd13: begin x = a | b;      y = a;          end
            4'd14: begin x = a | ~b;     y = a;          end
            default: begin x = a;        y = ones;       end
        endcase
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    function automatic exp_t predict(input logic [3:0] s, input logic m, input logic c,
                                     input logic dbl,
                                     input logic [W-1:0] ah, input logic [W-1:0] bh,
                                     input logic [W-1:0] al, input logic [W-1:0] bl);
        exp_t e;
        logic [W:0] lo, hi;
        lo = ref_alu(s, m, al, bl, c);
        e.lo = lo[W-1:0];
        if (!dbl) begin
            e.hi = '0;
            e.co = m ? 1'b0 : lo[W];
            e.z  = (lo[W-1:0] == '0);
        end else begin
            hi   = ref_alu(s, m, ah, bh, m ? 1'b0 : lo[W]);
            e.hi = hi[W-1:0];
            e.co = m ? 1'b0 : hi[W];
            e.z  = (lo[W-1:0] == '0) && (hi[W-1:0] == '0);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] t;
        case ($urandom_range(0, 5))
            0: t = '1;
            1: t = '0;
            2: t = 64'(W'(1));
            default: t = {$urandom(), $urandom()};
        endcase
        return t[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic m, input logic c, input logic dbl,
                         input logic [W-1:0] ah, input logic [W-1:0] bh,
                         input logic [W-1:0] al, input logic [W-1:0] bl);
        in_valid = 1'b1; op_s = s; op_boole = m; op_cin = c; op_dbl = dbl;
        a_hi = ah; b_hi = bh; a_lo = al; b_lo = bl;
    endtask

    task automatic rand_cycle(input bit allow_in);
        bit acc, take, hold, dbl_acc, sgl_acc, was_dhi;
        logic [79:0] snap;
        exp_t e;
        in_valid  = allow_in && ($urandom_range(0, 9) < 7);
        op_s      = 4'($urandom_range(0, 15));
        op_boole  = ($urandom_range(0, 3) == 0);
        op_cin    = 1'($urandom_range(0, 1));
        op_dbl    = ($urandom_range(0, 9) < 4);
        a_hi = rnd_word(); b_hi = rnd_word(); a_lo = rnd_word(); b_lo = rnd_word();
        out_ready = !allow_in || ($urandom_range(0, 9) < 6);
        #1;
        acc     = in_valid & in_ready;
        take    = out_valid & out_ready;
        hold    = out_valid & !out_ready;
        dbl_acc = acc & op_dbl;
        sgl_acc = acc & !op_dbl;
        was_dhi = in_dhi;
        snap    = {7'd0, out_valid, f_hi, f_lo};
        if (take) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("res_f_hi", f_hi, e.hi);
                check("res_f_lo", f_lo, e.lo);
                check("res_cout", cout, e.co);
                check("res_zero", zero, e.z);
            end
        end
        if (acc) exp_q.push_back(predict(op_s, op_boole, op_cin, op_dbl, a_hi, b_hi, a_lo, b_lo));
        step();
        if (hold)    check("hold_stable", {7'd0, out_valid, f_hi, f_lo}, snap);
        if (sgl_acc) check("single_latency", out_valid, 1);
        if (dbl_acc) begin
            check("dbl_mid_valid", out_valid, 0);
            check("dbl_mid_ready", in_ready, 0);
        end
        if (was_dhi) check("dbl_latency", out_valid, 1);
        in_dhi = dbl_acc;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_s = '0; op_boole = 1'b0; op_cin = 1'b0; op_dbl = 1'b0;
        a_hi = '0; b_hi = '0; a_lo = '0; b_lo = '0;

        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_outs", {out_valid, cout, zero, f_hi, f_lo}, 0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        drive(ALU_PASS_A, 1'b0, 1'b0, 1'b0, '0, '0, 36'o123456701234, 36'o777777777777);
        step();
        in_valid = 1'b0;
        check("pass_f_lo", f_lo, 36'o123456701234);
        check("pass_f_hi", f_hi, 0);
        check("pass_valid", out_valid, 1);

        drive(ALU_ADD, 1'b0, 1'b0, 1'b0, '0, '0, 36'o777777777777, 36'd1);
        step();
        in_valid = 1'b0;
        check("add_wrap", {out_valid, cout, zero, f_lo}, {3'b111, 36'd0});

        drive(ALU_ADD, 1'b0, 1'b0, 1'b1, '0, '0, 36'o777777777777, 36'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("dadd_busy", {in_ready, out_valid}, 0);
        check("dadd_mid_f_lo", f_lo, 0);
        step();
        check("dadd_res", {out_valid, cout, zero, f_hi, f_lo}, {3'b100, 36'd1, 36'd0});
        check("dadd_ready_back", in_ready, 1);

        step();
        out_ready = 1'b0;
        drive(ALU_ADD, 1'b0, 1'b0, 1'b0, '0, '0, 36'd5, 36'd7);
        step();
        check("bp_first", {out_valid, f_lo}, {1'b1, 36'd12});
        drive(ALU_ADD, 1'b0, 1'b1, 1'b0, '0, '0, 36'o100, 36'o1);
        #1;
        check("bp_no_accept", in_ready, 0);
        step();
        check("bp_hold1", {out_valid, f_lo}, {1'b1, 36'd12});
        step();
        check("bp_hold2", {out_valid, f_lo}, {1'b1, 36'd12});
        out_ready = 1'b1;
        #1;
        check("bp_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_second", {out_valid, f_lo}, {1'b1, 36'o102});
        step();
        check("bp_drained", out_valid, 0);

        drive(ALU_ADD, 1'b0, 1'b1, 1'b1, 36'd3, 36'd4, '1, '1);
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("dhi_rst_outs", {out_valid, cout, zero, f_hi, f_lo}, 0);
        #1;
        check("dhi_rst_idle", in_ready, 1);
        step();
        check("dhi_rst_no_result", out_valid, 0);
        drive(ALU_ADD, 1'b0, 1'b1, 1'b0, '0, '0, 36'd3, 36'd4);
        step();
        in_valid = 1'b0;
        check("post_rst_single", {out_valid, cout, zero, f_lo}, {3'b100, 36'd8});
        step();

        for (int i = 0; i < 600; i++) rand_cycle(1'b1);
        for (int i = 0; i < 6; i++) rand_cycle(1'b0);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
